// File: rtl/instr_expand_queue.sv
// Instruction expansion queue: stores compressed instruction records in a circular buffer and
// expands the head record into up to POP_WIDTH concrete instructions per cycle, with per-copy
// cache and main-memory addresses, behind a registered ready/valid output stage.
module instr_expand_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LOG_DEPTH = 4,
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned POP_WIDTH = 3,
    parameter int unsigned MAX_COPY  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_push_we,
    input  logic [15:0]                 i_push_instr,
    input  logic [1:0]                  i_push_instr_type,
    input  logic [ADDR_W-1:0]           i_push_cache_addr,
    input  logic [ADDR_W-1:0]           i_push_main_mem_addr,
    input  logic [ADDR_W-1:0]           i_push_d_cache_addr,
    input  logic [ADDR_W-1:0]           i_push_d_main_mem_addr,
    input  logic [3:0]                  i_push_copy_count,
    output logic                        o_push_full,
    output logic                        o_overflow,
    output logic [POP_WIDTH-1:0]        o_out_valid,
    output logic [POP_WIDTH-1:0]        o_out_last,
    output logic [POP_WIDTH*16-1:0]     o_out_instr,
    output logic [POP_WIDTH*2-1:0]      o_out_instr_type,
    output logic [POP_WIDTH*ADDR_W-1:0] o_out_cache_addr,
    output logic [POP_WIDTH*ADDR_W-1:0] o_out_main_mem_addr,
    input  logic                        i_out_ready
);

    localparam int unsigned PTR_W = LOG_DEPTH + 1;
    localparam int unsigned CNT_W = 4;

    // Record storage
    logic [15:0]       r_instr  [DEPTH];
    logic [1:0]        r_type   [DEPTH];
    logic [ADDR_W-1:0] r_cbase  [DEPTH];
    logic [ADDR_W-1:0] r_mbase  [DEPTH];
    logic [ADDR_W-1:0] r_dcache [DEPTH];
    logic [ADDR_W-1:0] r_dmain  [DEPTH];
    logic [CNT_W-1:0]  r_copies [DEPTH];

    // Control state
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_issued;
    logic             r_push_full;
    logic             r_overflow;

    // Output stage
    logic [POP_WIDTH-1:0]        r_out_valid;
    logic [POP_WIDTH-1:0]        r_out_last;
    logic [POP_WIDTH*16-1:0]     r_out_instr;
    logic [POP_WIDTH*2-1:0]      r_out_type;
    logic [POP_WIDTH*ADDR_W-1:0] r_out_caddr;
    logic [POP_WIDTH*ADDR_W-1:0] r_out_maddr;

    // Combinational helpers
    logic [PTR_W-1:0]            w_count;
    logic [PTR_W-1:0]            w_count_nxt;
    logic                        w_empty;
    logic                        w_push_ok;
    logic                        w_load;
    logic                        w_pop;
    logic                        w_final;
    logic [LOG_DEPTH-1:0]        w_head_idx;
    logic [LOG_DEPTH-1:0]        w_tail_idx;
    logic [CNT_W-1:0]            w_copies;
    logic [CNT_W-1:0]            w_remain;
    logic [CNT_W-1:0]            w_last_idx;
    logic [CNT_W-1:0]            w_norm_copies;
    logic [CNT_W-1:0]            w_copy_idx [POP_WIDTH];
    logic [POP_WIDTH-1:0]        w_nxt_valid;
    logic [POP_WIDTH-1:0]        w_nxt_last;
    logic [POP_WIDTH*16-1:0]     w_nxt_instr;
    logic [POP_WIDTH*2-1:0]      w_nxt_type;
    logic [POP_WIDTH*ADDR_W-1:0] w_nxt_caddr;
    logic [POP_WIDTH*ADDR_W-1:0] w_nxt_maddr;

    assign w_count    = r_tail - r_head;
    assign w_empty    = (w_count == '0);
    assign w_push_ok  = i_push_we & ~r_push_full;
    assign w_head_idx = r_head[LOG_DEPTH-1:0];
    assign w_tail_idx = r_tail[LOG_DEPTH-1:0];
    // The stage may be overwritten when it holds nothing or the consumer takes it this cycle
    assign w_load     = (r_out_valid == '0) | i_out_ready;
    assign w_copies   = r_copies[w_head_idx];
    assign w_remain   = w_copies - r_issued;
    assign w_last_idx = w_copies - CNT_W'(1);
    assign w_final    = (w_remain <= CNT_W'(POP_WIDTH));
    assign w_pop      = w_load & ~w_empty & w_final;
    assign w_count_nxt = w_count + PTR_W'(w_push_ok) - PTR_W'(w_pop);

    // Normalise the copy count: 0 means one copy, anything above MAX_COPY saturates
    always_comb begin
        w_norm_copies = i_push_copy_count;
        if (i_push_copy_count == '0) begin
            w_norm_copies = CNT_W'(1);
        end else if (i_push_copy_count > CNT_W'(MAX_COPY)) begin
            w_norm_copies = CNT_W'(MAX_COPY);
        end
    end

    // Copy index carried by each lane in the next load
    always_comb begin
        for (int j = 0; j < POP_WIDTH; j++) begin
            w_copy_idx[j] = r_issued + CNT_W'(j);
        end
    end

    // Build the next output-stage contents from the head record; unused lanes stay zero
    always_comb begin
        w_nxt_valid = '0;
        w_nxt_last  = '0;
        w_nxt_instr = '0;
        w_nxt_type  = '0;
        w_nxt_caddr = '0;
        w_nxt_maddr = '0;
        for (int j = 0; j < POP_WIDTH; j++) begin
            if (!w_empty && (CNT_W'(j) < w_remain)) begin
                w_nxt_valid[j]                  = 1'b1;
                w_nxt_last[j]                   = (w_copy_idx[j] == w_last_idx);
                w_nxt_instr[j*16 +: 16]         = r_instr[w_head_idx];
                w_nxt_type[j*2 +: 2]            = r_type[w_head_idx];
                // Unsigned wrap mod 2^ADDR_W; negative deltas arrive in two's complement
                w_nxt_caddr[j*ADDR_W +: ADDR_W] = r_cbase[w_head_idx]
                    + ADDR_W'(w_copy_idx[j]) * r_dcache[w_head_idx];
                w_nxt_maddr[j*ADDR_W +: ADDR_W] = r_mbase[w_head_idx]
                    + ADDR_W'(w_copy_idx[j]) * r_dmain[w_head_idx];
            end
        end
    end

    // Write accepted records into storage at the tail slot
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_instr[w_tail_idx]  <= i_push_instr;
            r_type[w_tail_idx]   <= i_push_instr_type;
            r_cbase[w_tail_idx]  <= i_push_cache_addr;
            r_mbase[w_tail_idx]  <= i_push_main_mem_addr;
            r_dcache[w_tail_idx] <= i_push_d_cache_addr;
            r_dmain[w_tail_idx]  <= i_push_d_main_mem_addr;
            r_copies[w_tail_idx] <= w_norm_copies;
        end
    end

    // Pointers, issue counter, full flag and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_issued    <= '0;
            r_push_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (i_push_we && r_push_full) begin
                r_overflow <= 1'b1;
            end
            if (w_load && !w_empty) begin
                if (w_final) begin
                    r_head   <= r_head + PTR_W'(1);
                    r_issued <= '0;
                end else begin
                    r_issued <= r_issued + CNT_W'(POP_WIDTH);
                end
            end
            r_push_full <= (w_count_nxt == PTR_W'(DEPTH));
        end
    end

    // Registered output stage; holds while valid and not accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= '0;
            r_out_last  <= '0;
            r_out_instr <= '0;
            r_out_type  <= '0;
            r_out_caddr <= '0;
            r_out_maddr <= '0;
        end else if (w_load) begin
            r_out_valid <= w_nxt_valid;
            r_out_last  <= w_nxt_last;
            r_out_instr <= w_nxt_instr;
            r_out_type  <= w_nxt_type;
            r_out_caddr <= w_nxt_caddr;
            r_out_maddr <= w_nxt_maddr;
        end
    end

    assign o_push_full         = r_push_full;
    assign o_overflow          = r_overflow;
    assign o_out_valid         = r_out_valid;
    assign o_out_last          = r_out_last;
    assign o_out_instr         = r_out_instr;
    assign o_out_instr_type    = r_out_type;
    assign o_out_cache_addr    = r_out_caddr;
    assign o_out_main_mem_addr = r_out_maddr;

endmodule
